// File: rtl/seq_detector_param.sv
// Serial pattern detector: scans a loaded parallel word MSB-first and pulses Z on each match.
// Optional saturating match counter enabled by defining SEQ_DET_COUNT_EN.
module seq_detector_param #(
    parameter int unsigned           WORD_W  = 7,
    parameter int unsigned           PAT_W   = 3,
    parameter logic [PAT_W-1:0]      PATTERN = 3'b101,
    parameter int unsigned           IDX_W   = 3,
    parameter int unsigned           CNT_W   = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WORD_W-1:0] X,
    input  logic             overlap,
    output logic             Z,
    output logic [1:0]       state,
    output logic [IDX_W-1:0] n,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] match_count
);

    localparam int unsigned FillW = $clog2(PAT_W + 1);
    localparam logic [FillW-1:0] FillFull = FillW'(PAT_W);
    localparam logic [IDX_W-1:0] LastIdx = IDX_W'(WORD_W - 1);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StShift = 2'd1,
        StDone  = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [WORD_W-1:0]   word_q, word_d;
    logic                ovl_q, ovl_d;
    logic [PAT_W-1:0]    window_q, window_d;
    logic [FillW-1:0]    fill_q, fill_d;
    logic [IDX_W-1:0]    n_q, n_d;
    logic                z_q, z_d;

    always_comb begin
        state_d  = state_q;
        word_d   = word_q;
        ovl_d    = ovl_q;
        window_d = window_q;
        fill_d   = fill_q;
        n_d      = n_q;
        z_d      = 1'b0;
        case (state_q)
            StIdle: begin
                if (load) begin
                    word_d   = X;
                    ovl_d    = overlap;
                    window_d = '0;
                    fill_d   = '0;
                    n_d      = '0;
                    state_d  = StShift;
                end
            end
            StShift: begin
                // word_q is shifted left so its MSB is always bit X[WORD_W-1-n].
                window_d = {window_q[PAT_W-2:0], word_q[WORD_W-1]};
                word_d   = {word_q[WORD_W-2:0], 1'b0};
                fill_d   = (fill_q == FillFull) ? fill_q : fill_q + FillW'(1);
                if ((window_d == PATTERN) && (fill_d == FillFull)) begin
                    z_d = 1'b1;
                    if (!ovl_q) begin
                        fill_d = '0;
                    end
                end
                if (n_q == LastIdx) begin
                    state_d = StDone;
                end else begin
                    n_d = n_q + IDX_W'(1);
                end
            end
            StDone: begin
                state_d = StIdle;
                n_d     = '0;
            end
            default: begin
                state_d = StIdle;
                n_d     = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            word_q   <= '0;
            ovl_q    <= 1'b0;
            window_q <= '0;
            fill_q   <= '0;
            n_q      <= '0;
            z_q      <= 1'b0;
        end else begin
            state_q  <= state_d;
            word_q   <= word_d;
            ovl_q    <= ovl_d;
            window_q <= window_d;
            fill_q   <= fill_d;
            n_q      <= n_d;
            z_q      <= z_d;
        end
    end

`ifdef SEQ_DET_COUNT_EN
    logic [CNT_W-1:0] cnt_q;

    // Counts in step with the Z register, so it already includes a pulse while Z is high.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (z_d && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign match_count = cnt_q;
`else
    assign match_count = '0;
`endif

    assign Z     = z_q;
    assign state = state_q;
    assign n     = n_q;
    assign busy  = (state_q == StShift);
    assign done  = (state_q == StDone);

endmodule
